uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receive path; the counterpart of the UART transmit serializer.
- Oversamples a serial RX line, detects the start bit, and majority-votes each bit at mid-bit.
- Deserializes DATA_WIDTH bits LSB first, checks the stop bit (and parity when compiled in), and presents parallel data with a one-cycle valid pulse.
- Sits between the pad and the byte-level consumer (register file / FIFO).

Parameters:
- DATA_WIDTH, 8, data bits per frame.
- PRESCALE, 8, CLK cycles per bit period. Must be even and >= 4.

Ports:
- CLK  input  1  oversampling clock; PRESCALE cycles per bit.
- RST  input  1  reset; one clock, reset is asynchronous and active-high.
- RX_IN  input  1  asynchronous serial line; idle high.
- PAR_TYP  input  1  parity type: 0 = even, 1 = odd. Used only with the optional feature.
- P_DATA  output  DATA_WIDTH  last good received word; LSB = first data bit.
- data_valid  output  1  one-cycle pulse; P_DATA updated with a good frame.
- stop_err  output  1  one-cycle pulse; sampled stop bit was 0.
- par_err  output  1  one-cycle pulse; parity mismatch (optional feature only).
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values:
  - P_DATA = 0; data_valid, stop_err, par_err = 0; busy = 0.
  - FSM = IDLE; counters = 0.
  - Both synchronizer flops = 1.
- Synchronizer: RX_IN passes through 2 flops. All logic below uses the synchronized value rx_s.
- Counters:
  - edge_cnt: width clog2(PRESCALE); runs 0..PRESCALE-1, then wraps to 0 and closes a bit.
  - bit_cnt: width clog2(DATA_WIDTH+1).
- Sampling:
  - Samples are taken at edge_cnt = PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1.
  - The bit value is the majority of the 3 samples, valid from edge_cnt = PRESCALE/2+2 onward.
- FSM states and transitions:
  - IDLE: rx_s == 0 -> START, edge_cnt = 0, PAR_TYP latched. Otherwise stay.
  - START: at edge_cnt = PRESCALE-1, if majority = 1 (glitch) -> IDLE with no error pulse; else -> DATA with bit_cnt = 0.
  - DATA: at edge_cnt = PRESCALE-1, shift majority in from the MSB side of the internal shift register (LSB-first wire order) and increment bit_cnt. After DATA_WIDTH bits -> PARITY if enabled, else STOP.
  - PARITY: at edge_cnt = PRESCALE-1, store the majority bit -> STOP.
  - STOP: decide at the end of the cycle with edge_cnt = PRESCALE/2+1 (third sample) and go to IDLE immediately. This leaves margin for back-to-back frames and a fast transmitter.
- Stop decision:
  - Majority 1 and no parity error: P_DATA <= shift register and data_valid = 1 for 1 cycle.
  - Majority 0: stop_err = 1 and P_DATA holds.
  - Parity error: par_err = 1 and P_DATA holds. stop_err and par_err may pulse together; data_valid stays 0 in either error case.
- Back-to-back frames: IDLE may accept a new start on the cycle after STOP exits.
- Latency: let N be the CLK edge that first captures RX_IN low. data_valid is high after edge N + 3 + (DATA_WIDTH+1+P)*PRESCALE + PRESCALE/2 + 1, where P = 1 with parity, else 0. For defaults this is N+80 without parity, N+88 with parity.
- Reset mid-frame: immediate return to IDLE with all reset values; the partial frame is discarded with no pulses.
- P_DATA is stable between data_valid pulses.
- Line held low (break): produces a stop_err pulse, then a new start is detected immediately. This is repeated every frame time; no special break handling.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - The PARITY state exists; frame length is DATA_WIDTH+3 bits.
  - Expected parity = XOR of data bits XOR latched PAR_TYP; a mismatch drives par_err.
- Undefined:
  - No PARITY state; frame length is DATA_WIDTH+2 bits.
  - PAR_TYP is ignored and par_err is tied to 0.

Test Plan:
- Single frame 0xA5, defaults, no parity, 8 CLK per bit -> P_DATA = 0xA5, data_valid high for exactly 1 cycle at N+80, stop_err = 0.
- 2-cycle low glitch on idle RX_IN -> returns to IDLE; no data_valid, stop_err or par_err; busy high for at most PRESCALE cycles.
- Frame 0x3C with stop bit 0 -> stop_err pulse; data_valid = 0; P_DATA keeps its previous value 0xA5.
- UART_RX_PARITY_EN, PAR_TYP = 0, frame 0x07 with parity bit 1 -> data_valid at N+88, P_DATA = 0x07. Same frame with parity bit 0 -> par_err pulse and no data_valid.
- Frames 0x55 then 0xFF back-to-back with 1 stop bit and a transmitter 3% fast -> two data_valid pulses with correct values.
- RST asserted during data bit 4 of a frame, released, then frame 0x81 -> no pulse for the aborted frame; P_DATA = 0x81 after the second frame.

Source files
------------

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : Oversampled UART receiver with 3-sample majority vote; optional
//             parity check compiled in with macro UART_RX_PARITY_EN.
//  Revision : 1.0
// ============================================================================
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  stop_err,
    output logic                  par_err,
    output logic                  busy
);

    localparam int c_EDGE_W = $clog2(PRESCALE);
    localparam int c_BIT_W  = $clog2(DATA_WIDTH + 1);

    localparam logic [c_EDGE_W-1:0] c_EDGE_LAST = c_EDGE_W'(PRESCALE - 1);
    localparam logic [c_EDGE_W-1:0] c_SAMP0     = c_EDGE_W'(PRESCALE / 2 - 1);
    localparam logic [c_EDGE_W-1:0] c_SAMP1     = c_EDGE_W'(PRESCALE / 2);
    localparam logic [c_EDGE_W-1:0] c_SAMP2     = c_EDGE_W'(PRESCALE / 2 + 1);
    localparam logic [c_EDGE_W-1:0] c_EDGE_ONE  = c_EDGE_W'(1);
    localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(DATA_WIDTH - 1);
    localparam logic [c_BIT_W-1:0]  c_BIT_ONE   = c_BIT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_sync1;
    logic                  r_sync2;
    logic                  w_rx_s;
    logic [c_EDGE_W-1:0]   r_edge_cnt;
    logic [c_EDGE_W-1:0]   w_edge_nxt;
    logic [c_BIT_W-1:0]    r_bit_cnt;
    logic [c_BIT_W-1:0]    w_bit_nxt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic [DATA_WIDTH-1:0] w_pdata_nxt;
    logic [2:0]            r_samp;
    logic                  w_edge_last;
    logic                  w_maj_reg;
    logic                  w_maj_stop;
    logic                  w_par_bad;
    logic                  w_dv_nxt;
    logic                  w_serr_nxt;
    logic                  w_perr_nxt;

    // Two-flop synchronizer; idle-high reset value avoids a false start.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= RX_IN;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s = r_sync2;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_samp <= 3'b000;
        end else begin
            if (r_edge_cnt == c_SAMP0) r_samp[0] <= w_rx_s;
            if (r_edge_cnt == c_SAMP1) r_samp[1] <= w_rx_s;
            if (r_edge_cnt == c_SAMP2) r_samp[2] <= w_rx_s;
        end
    end

    assign w_edge_last = (r_edge_cnt == c_EDGE_LAST);
    assign w_maj_reg   = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_samp[2]) | (r_samp[1] & r_samp[2]);
    // STOP decides in the cycle of the third sample, so that sample is taken live.
    assign w_maj_stop  = (r_samp[0] & r_samp[1]) | (r_samp[0] & w_rx_s) | (r_samp[1] & w_rx_s);

`ifdef UART_RX_PARITY_EN
    logic r_par_typ;
    logic w_par_typ_nxt;
    logic r_par_bit;
    logic w_par_bit_nxt;

    assign w_par_bad = r_par_bit != ((^r_shift) ^ r_par_typ);
`else
    logic w_unused_par_typ;

    assign w_unused_par_typ = PAR_TYP;
    assign w_par_bad        = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_edge_nxt  = w_edge_last ? '0 : r_edge_cnt + c_EDGE_ONE;
        w_bit_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_pdata_nxt = P_DATA;
        w_dv_nxt    = 1'b0;
        w_serr_nxt  = 1'b0;
        w_perr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_typ_nxt = r_par_typ;
        w_par_bit_nxt = r_par_bit;
`endif
        case (r_state)
            S_IDLE: begin
                w_edge_nxt = '0;
                if (!w_rx_s) begin
                    w_state_nxt = S_START;
`ifdef UART_RX_PARITY_EN
                    w_par_typ_nxt = PAR_TYP;
`endif
                end
            end
            S_START: begin
                if (w_edge_last) begin
                    if (w_maj_reg) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_DATA;
                        w_bit_nxt   = '0;
                    end
                end
            end
            S_DATA: begin
                if (w_edge_last) begin
                    w_shift_nxt = {w_maj_reg, r_shift[DATA_WIDTH-1:1]};
                    w_bit_nxt   = r_bit_cnt + c_BIT_ONE;
                    if (r_bit_cnt == c_BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (w_edge_last) begin
                    w_par_bit_nxt = w_maj_reg;
                    w_state_nxt   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (r_edge_cnt == c_SAMP2) begin
                    w_state_nxt = S_IDLE;
                    w_edge_nxt  = '0;
                    w_serr_nxt  = !w_maj_stop;
                    w_perr_nxt  = w_par_bad;
                    if (w_maj_stop && !w_par_bad) begin
                        w_dv_nxt    = 1'b1;
                        w_pdata_nxt = r_shift;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_edge_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            P_DATA     <= '0;
            data_valid <= 1'b0;
            stop_err   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_edge_cnt <= w_edge_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            P_DATA     <= w_pdata_nxt;
            data_valid <= w_dv_nxt;
            stop_err   <= w_serr_nxt;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_par_typ <= 1'b0;
            r_par_bit <= 1'b0;
            par_err   <= 1'b0;
        end else begin
            r_par_typ <= w_par_typ_nxt;
            r_par_bit <= w_par_bit_nxt;
            par_err   <= w_perr_nxt;
        end
    end
`else
    logic w_unused_perr;

    assign w_unused_perr = w_perr_nxt;
    assign par_err       = 1'b0;
`endif

    assign busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx
//  Purpose  : Directed self-checking bench for uart_rx (parity cases under
//             UART_RX_PARITY_EN).
//  Revision : 1.0
// ============================================================================
module tb_uart_rx;

    localparam int c_PS     = 8;
    localparam int c_CLK_T  = 100;
    localparam int c_BIT_T  = c_PS * c_CLK_T;
`ifdef UART_RX_PARITY_EN
    localparam int c_LAT    = 88;
`else
    localparam int c_LAT    = 80;
    localparam int c_FAST_T = 776;
`endif

    logic       CLK     = 1'b0;
    logic       RST     = 1'b1;
    logic       RX_IN   = 1'b1;
    logic       PAR_TYP = 1'b0;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       stop_err;
    logic       par_err;
    logic       busy;

`ifdef UART_RX_PARITY_EN
    logic par_flip = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int dv_cnt   = 0;
    int serr_cnt = 0;
    int perr_cnt = 0;
    int busy_cyc = 0;
    int dv_cyc   = 0;
    logic [7:0] dv_q[$];

    uart_rx #(
        .DATA_WIDTH(8),
        .PRESCALE  (c_PS)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .RX_IN     (RX_IN),
        .PAR_TYP   (PAR_TYP),
        .P_DATA    (P_DATA),
        .data_valid(data_valid),
        .stop_err  (stop_err),
        .par_err   (par_err),
        .busy      (busy)
    );

    always #(c_CLK_T / 2) CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (data_valid) begin
            dv_cnt <= dv_cnt + 1;
            dv_cyc <= cyc;
            dv_q.push_back(P_DATA);
        end
        if (stop_err) serr_cnt <= serr_cnt + 1;
        if (par_err)  perr_cnt <= perr_cnt + 1;
        if (busy)     busy_cyc <= busy_cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Place the next line transition one time unit before a rising edge.
    task automatic align();
        @(posedge CLK);
        #(c_CLK_T - 1);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input int bit_t,
                              output int n_edge);
        n_edge = cyc + 1;
        RX_IN  = 1'b0;
        #(bit_t);
        for (int i = 0; i < 8; i++) begin
            RX_IN = d[i];
            #(bit_t);
        end
`ifdef UART_RX_PARITY_EN
        RX_IN = (^d) ^ PAR_TYP ^ par_flip;
        #(bit_t);
`endif
        RX_IN = stop_b;
        #(bit_t);
        RX_IN = 1'b1;
    endtask

    initial begin
        int n;
        int dv0, se0, pe0, b0;
        logic [7:0] pat;

        repeat (3) @(posedge CLK);
        #1;
        chk("rst_p_data", P_DATA, 8'h00);
        chk("rst_data_valid", data_valid, 1'b0);
        chk("rst_stop_err", stop_err, 1'b0);
        chk("rst_par_err", par_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (5) @(posedge CLK);

        // Single aligned frame 0xA5
        align();
        dv0 = dv_cnt; se0 = serr_cnt;
        send_frame(8'hA5, 1'b1, c_BIT_T, n);
        #(2 * c_BIT_T);
        chk("a5_dv_count", dv_cnt - dv0, 1);
        chk("a5_latency", dv_cyc - n, c_LAT);
        chk("a5_p_data", P_DATA, 8'hA5);
        chk("a5_stop_err", serr_cnt - se0, 0);

        // Two-cycle low glitch on an idle line
        align();
        dv0 = dv_cnt; se0 = serr_cnt; pe0 = perr_cnt; b0 = busy_cyc;
        RX_IN = 1'b0;
        #(2 * c_CLK_T);
        RX_IN = 1'b1;
        #(4 * c_BIT_T);
        chk("glitch_busy_le_ps", (busy_cyc - b0) <= c_PS, 1);
        chk("glitch_busy_seen", (busy_cyc - b0) > 0, 1);
        chk("glitch_pulses", (dv_cnt - dv0) + (serr_cnt - se0) + (perr_cnt - pe0), 0);

        // Frame 0x3C with a zero stop bit
        align();
        dv0 = dv_cnt; se0 = serr_cnt;
        send_frame(8'h3C, 1'b0, c_BIT_T, n);
        #(2 * c_BIT_T);
        chk("serr_pulse", serr_cnt - se0, 1);
        chk("serr_no_dv", dv_cnt - dv0, 0);
        chk("serr_p_data_hold", P_DATA, 8'hA5);

`ifdef UART_RX_PARITY_EN
        // Even parity, 0x07 has three ones so the parity bit is 1
        PAR_TYP = 1'b0;
        par_flip = 1'b0;
        align();
        dv0 = dv_cnt; pe0 = perr_cnt;
        send_frame(8'h07, 1'b1, c_BIT_T, n);
        #(2 * c_BIT_T);
        chk("par_ok_dv", dv_cnt - dv0, 1);
        chk("par_ok_latency", dv_cyc - n, 88);
        chk("par_ok_p_data", P_DATA, 8'h07);
        par_flip = 1'b1;
        align();
        dv0 = dv_cnt; pe0 = perr_cnt;
        send_frame(8'h07, 1'b1, c_BIT_T, n);
        #(2 * c_BIT_T);
        par_flip = 1'b0;
        chk("par_bad_pulse", perr_cnt - pe0, 1);
        chk("par_bad_no_dv", dv_cnt - dv0, 0);
`else
        // Back-to-back frames from a transmitter 3% fast
        align();
        dv0 = dv_cnt; se0 = serr_cnt;
        send_frame(8'h55, 1'b1, c_FAST_T, n);
        send_frame(8'hFF, 1'b1, c_FAST_T, n);
        #(2 * c_BIT_T);
        chk("b2b_dv_count", dv_cnt - dv0, 2);
        chk("b2b_first", (dv_q.size() >= 2) ? dv_q[dv_q.size() - 2] : 8'hxx, 8'h55);
        chk("b2b_second", (dv_q.size() >= 1) ? dv_q[dv_q.size() - 1] : 8'hxx, 8'hFF);
        chk("b2b_stop_err", serr_cnt - se0, 0);
`endif

        // Reset during data bit 4, then frame 0x81
        align();
        dv0 = dv_cnt; se0 = serr_cnt; pe0 = perr_cnt;
        pat = 8'h5A;
        RX_IN = 1'b0;
        #(c_BIT_T);
        for (int i = 0; i < 4; i++) begin
            RX_IN = pat[i];
            #(c_BIT_T);
        end
        RX_IN = pat[4];
        #(c_BIT_T / 2);
        RST   = 1'b1;
        RX_IN = 1'b1;
        #(2 * c_CLK_T);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_p_data", P_DATA, 8'h00);
        RST = 1'b0;
        #(4 * c_BIT_T);
        chk("midrst_no_pulses", (dv_cnt - dv0) + (serr_cnt - se0) + (perr_cnt - pe0), 0);
        align();
        dv0 = dv_cnt;
        send_frame(8'h81, 1'b1, c_BIT_T, n);
        #(2 * c_BIT_T);
        chk("after_rst_dv", dv_cnt - dv0, 1);
        chk("after_rst_p_data", P_DATA, 8'h81);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
